// File: rtl/converte_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   estado_t       : controller states (OCIOSO, CONVERTE, FIM)
//   largura_cont() : width of the bit counter needed to hold LARGURA
package converte_bcd_seq_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    FIM      = 2'd2
  } estado_t;

  // The counter is loaded with LARGURA itself, so it must hold LARGURA (not LARGURA-1).
  function automatic int largura_cont(input int largura);
    return $clog2(largura + 1);
  endfunction

endpackage

// File: rtl/converte_bcd_seq_ajuste_bcd.sv
// One double-dabble correction stage: a BCD digit >= 5 gets +3 so that the
// following left shift carries correctly into the next decimal digit.
//   d : input digit
//   q : corrected digit
module ajuste_bcd (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/converte_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
//   clock, reset : clock and synchronous active-high reset
//   inicio       : start request, accepted only while idle
//   entrada      : unsigned value, captured on the accepted inicio
//   ocupado      : conversion in progress
//   pronto       : one-cycle pulse, new result valid
//   digitos      : packed BCD digits, units in [3:0]
//   estouro      : last value did not fit in NUM_DIGITOS digits
//   apagar       : leading-zero blanking mask (bit 0 always 0)
module converte_bcd_seq
  import converte_bcd_seq_pkg::*;
#(
  parameter int LARGURA     = 32,
  parameter int NUM_DIGITOS = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     inicio,
  input  logic [LARGURA-1:0]       entrada,
  output logic                     ocupado,
  output logic                     pronto,
  output logic [4*NUM_DIGITOS-1:0] digitos,
  output logic                     estouro,
  output logic [NUM_DIGITOS-1:0]   apagar
);

  localparam int LC = largura_cont(LARGURA);
  localparam int LB = 4 * NUM_DIGITOS;

  estado_t            estado, prox;
  logic [LARGURA-1:0] desloc, desloc_prox;
  logic [LB-1:0]      bcd, bcd_aj, bcd_prox;
  logic [LC-1:0]      cont;
  logic               acum, saida, ultimo;
  logic [NUM_DIGITOS-1:0] apagar_prox;

  // Per-digit add-3 correction ahead of the shift.
  for (genvar g = 0; g < NUM_DIGITOS; g++) begin : g_aj
    ajuste_bcd u_aj (
      .d(bcd[4*g +: 4]),
      .q(bcd_aj[4*g +: 4])
    );
  end

  // {bcd, desloc} shifts left by one; the top BCD bit falls out and only
  // feeds the overflow accumulator, which is what makes digitos = value mod 10^N.
  assign saida = bcd_aj[LB-1];
  assign {bcd_prox, desloc_prox} = {bcd_aj[LB-2:0], desloc, 1'b0};
  assign ultimo = (cont == LC'(1));

  // A digit is blanked when it and every digit above it are zero.
  always_comb begin
    logic zero;
    zero        = 1'b1;
    apagar_prox = '0;
    for (int k = NUM_DIGITOS - 1; k >= 1; k--) begin
      zero           = zero & (bcd_prox[4*k +: 4] == 4'd0);
      apagar_prox[k] = zero;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) estado <= OCIOSO;
    else       estado <= prox;
  end

  // Next-state logic
  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:   if (inicio) prox = CONVERTE;
      CONVERTE: if (ultimo) prox = FIM;
      FIM:      prox = OCIOSO;
      default:  prox = OCIOSO;
    endcase
  end

  // Outputs
  always_comb begin
    ocupado = (estado == CONVERTE);
    pronto  = (estado == FIM);
  end

  // Datapath and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      desloc  <= '0;
      bcd     <= '0;
      acum    <= 1'b0;
      cont    <= '0;
      digitos <= '0;
      estouro <= 1'b0;
      apagar  <= '0;
    end else begin
      case (estado)
        OCIOSO: if (inicio) begin
          desloc <= entrada;
          bcd    <= '0;
          acum   <= 1'b0;
          cont   <= LC'(LARGURA);
        end
        CONVERTE: begin
          desloc <= desloc_prox;
          bcd    <= bcd_prox;
          acum   <= acum | saida;
          cont   <= cont - LC'(1);
          // Results load together with the final step, on entry to FIM.
          if (ultimo) begin
            digitos <= bcd_prox;
            estouro <= acum | saida;
            apagar  <= apagar_prox;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_converte_bcd_seq.sv
// Bench for converte_bcd_seq: a default instance (32 bits, 4 digits) and an
// overridden one (8 bits, 3 digits), each followed by a decimal-arithmetic
// model checked every cycle, plus directed literal expectations.
module tb_converte_bcd_seq;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_a, inicio_a, ocupado_a, pronto_a, estouro_a;
  logic [31:0] entrada_a;
  logic [15:0] digitos_a;
  logic [3:0]  apagar_a;

  logic        reset_b, inicio_b, ocupado_b, pronto_b, estouro_b;
  logic [7:0]  entrada_b;
  logic [11:0] digitos_b;
  logic [2:0]  apagar_b;

  converte_bcd_seq dut_a (
    .clock(clock), .reset(reset_a), .inicio(inicio_a), .entrada(entrada_a),
    .ocupado(ocupado_a), .pronto(pronto_a), .digitos(digitos_a),
    .estouro(estouro_a), .apagar(apagar_a)
  );

  converte_bcd_seq #(.LARGURA(8), .NUM_DIGITOS(3)) dut_b (
    .clock(clock), .reset(reset_b), .inicio(inicio_b), .entrada(entrada_b),
    .ocupado(ocupado_b), .pronto(pronto_b), .digitos(digitos_b),
    .estouro(estouro_b), .apagar(apagar_b)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic int lar(input int i); return (i == 0) ? 32 : 8; endfunction
  function automatic int ndig(input int i); return (i == 0) ? 4 : 3; endfunction

  int          fase [2];   // 0 idle, 1 converting, 2 result pulse
  int          rest [2];
  longint      val  [2];
  logic [15:0] e_dig[2];
  logic        e_est[2];
  logic [3:0]  e_apg[2];

  task automatic calcula(input int i);
    longint p, m;
    p = 1;
    for (int k = 0; k < ndig(i); k++) p = p * 10;
    m = val[i] % p;
    e_est[i] = (val[i] >= p);
    e_dig[i] = '0;
    e_apg[i] = '0;
    for (int k = 0; k < ndig(i); k++) begin
      longint pk;
      pk = 1;
      for (int j = 0; j < k; j++) pk = pk * 10;
      e_dig[i][4*k +: 4] = 4'((m / pk) % 10);
      if (k >= 1) e_apg[i][k] = ((m / pk) == 0);
    end
  endtask

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      logic rst, ini;
      longint ent;
      rst = (i == 0) ? reset_a  : reset_b;
      ini = (i == 0) ? inicio_a : inicio_b;
      ent = (i == 0) ? longint'(entrada_a) : longint'(entrada_b);
      if (rst) begin
        fase[i] = 0; rest[i] = 0; e_dig[i] = '0; e_est[i] = 1'b0; e_apg[i] = '0;
      end else begin
        case (fase[i])
          0: if (ini) begin val[i] = ent; rest[i] = lar(i); fase[i] = 1; end
          1: begin
            rest[i] = rest[i] - 1;
            if (rest[i] == 0) begin fase[i] = 2; calcula(i); end
          end
          default: fase[i] = 0;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (chk_on) begin
      check("ocupado_a", 32'(ocupado_a), 32'(fase[0] == 1));
      check("pronto_a",  32'(pronto_a),  32'(fase[0] == 2));
      check("digitos_a", 32'(digitos_a), 32'(e_dig[0]));
      check("estouro_a", 32'(estouro_a), 32'(e_est[0]));
      check("apagar_a",  32'(apagar_a),  32'(e_apg[0]));
      check("excl_a",    32'(ocupado_a & pronto_a), 32'(0));
      check("ocupado_b", 32'(ocupado_b), 32'(fase[1] == 1));
      check("pronto_b",  32'(pronto_b),  32'(fase[1] == 2));
      check("digitos_b", 32'(digitos_b), 32'(e_dig[1][11:0]));
      check("estouro_b", 32'(estouro_b), 32'(e_est[1]));
      check("apagar_b",  32'(apagar_b),  32'(e_apg[1][2:0]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic conv_a(input logic [31:0] v, input logic [15:0] xd,
                        input logic xe, input logic [3:0] xa);
    int n;
    @(posedge clock); #1;
    entrada_a = v; inicio_a = 1'b1;
    @(posedge clock); #1;
    inicio_a = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clock); n++;
      if (pronto_a) break;
    end
    check("lat_a", 32'(n), 32'd33);
    check("lit_dig_a", 32'(digitos_a), 32'(xd));
    check("lit_est_a", 32'(estouro_a), 32'(xe));
    check("lit_apg_a", 32'(apagar_a),  32'(xa));
  endtask

  initial begin
    int n, np;
    logic [15:0] d56;
    logic [3:0]  a56;
    reset_a = 1'b1; inicio_a = 1'b0; entrada_a = '0;
    reset_b = 1'b1; inicio_b = 1'b0; entrada_b = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_a", {ocupado_a, pronto_a, digitos_a, estouro_a, apagar_a}, 32'd0);
    check("rst_b", {ocupado_b, pronto_b, digitos_b, estouro_b, apagar_b}, 32'd0);
    reset_a = 1'b0; reset_b = 1'b0;
    chk_on = 1'b1;

    conv_a(32'd1234,       16'h1234, 1'b0, 4'b0000);
    conv_a(32'd0,          16'h0000, 1'b0, 4'b1110);
    conv_a(32'd7,          16'h0007, 1'b0, 4'b1110);
    conv_a(32'd9999,       16'h9999, 1'b0, 4'b0000);
    conv_a(32'd10000,      16'h0000, 1'b1, 4'b1110);
    conv_a(32'hFFFFFFFF,   16'h7295, 1'b1, 4'b0000);

    // inicio during a conversion is ignored
    @(posedge clock); #1;
    entrada_a = 32'd56; inicio_a = 1'b1;
    @(posedge clock); #1;
    inicio_a = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    entrada_a = 32'd999; inicio_a = 1'b1;
    @(posedge clock); #1;
    inicio_a = 1'b0;
    np = 0; d56 = '0; a56 = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (pronto_a) begin
        if (np == 0) begin d56 = digitos_a; a56 = apagar_a; end
        np++;
      end
    end
    check("pronto_once", 32'(np), 32'd1);
    check("lit_dig_56", 32'(d56), 32'h0056);
    check("lit_apg_56", 32'(a56), 32'b1100);
    conv_a(32'd123, 16'h0123, 1'b0, 4'b1000);

    // reset in the middle of a conversion
    @(posedge clock); #1;
    entrada_a = 32'd4321; inicio_a = 1'b1;
    @(posedge clock); #1;
    inicio_a = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    reset_a = 1'b1;
    @(posedge clock); #1;
    reset_a = 1'b0;
    check("rst_mid", {ocupado_a, pronto_a, digitos_a, estouro_a, apagar_a}, 32'd0);
    conv_a(32'd4321, 16'h4321, 1'b0, 4'b0000);

    // overridden instance: 8 bits, 3 digits
    @(posedge clock); #1;
    entrada_b = 8'd255; inicio_b = 1'b1;
    @(posedge clock); #1;
    inicio_b = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clock); n++;
      if (pronto_b) break;
    end
    check("lat_b", 32'(n), 32'd9);
    check("lit_dig_b", 32'(digitos_b), 32'h255);
    check("lit_est_b", 32'(estouro_b), 32'd0);
    check("lit_apg_b", 32'(apagar_b),  32'd0);

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
